lsu_ctrl: RTL
=============

Name: lsu_ctrl

Overview:
- Parametrised load/store unit between the core datapath and the data-memory port.
- Replaces the ad-hoc registered dmem_ren/dmem_wen and the combinational load extender with a handshake FSM, byte-lane alignment, write strobes, misalignment/timeout detection and a pipeline stall.
- Supports XLEN 32 or 64 (RV32/RV64 loads/stores).

Parameters:
- XLEN, 32, data width; legal values are 32 and 64.
- ADDR_W, 32, byte-address width.
- MAX_WAIT, 255, cycles to wait for dhit before a timeout error; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  memory op request from execute
- req_ready  out  1  LSU can accept a request
- req_wen  in  1  1 = store, 0 = load
- req_width  in  2  00 B, 01 H, 10 W, 11 D
- req_unsigned  in  1  zero-extend the load
- req_addr  in  ADDR_W  byte address (ALU output)
- req_wdata  in  XLEN  store data (rs2)
- req_rd  in  5  destination tag, returned with the response
- resp_valid  out  1  one-cycle completion pulse
- resp_data  out  XLEN  extended load data; 0 for stores and errors
- resp_rd  out  5  tag of the completed op
- resp_err  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal width
- stall  out  1  hold upstream pipeline
- dmem_ren  out  1  memory read enable
- dmem_wen  out  1  memory write enable
- dmem_addr  out  ADDR_W  req_addr with the low log2(XLEN/8) bits cleared
- dmem_store  out  XLEN  write data shifted to its byte lane
- dmem_strobe  out  XLEN/8  byte write enables
- dmem_load  in  XLEN  read data, valid when dhit=1
- dhit  in  1  memory completion

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset forces IDLE. During reset all outputs are 0, the wait counter is 0, and dmem_ren/dmem_wen drop immediately, abandoning any in-flight access.
- req_ready = (state == IDLE).
- stall = (IDLE and req_valid) or ACCESS. stall is 0 in RESP.
- Accept: req_valid & req_ready on cycle N. All request fields are latched. Checks are made at accept:
  - width 11 with XLEN=32 → err 11.
  - address not aligned to the access size (H: addr[0]; W: addr[1:0]; D: addr[2:0]) → err 01.
- Error at accept: go to RESP at N+1. No dmem enable is ever raised.
- Otherwise go to ACCESS at N+1:
  - dmem_ren = !wen, dmem_wen = wen; both registered, stable until exit.
  - dmem_addr, dmem_store and dmem_strobe are driven from the latched fields.
- Lane L = latched addr[log2(XLEN/8)-1:0].
  - dmem_store = wdata << (8*L).
  - dmem_strobe = (1<<size)-1 << L, where size is 1, 2, 4 or 8 bytes.
- ACCESS with dhit=1: capture the load as (dmem_load >> 8*L), truncated to size and sign- or zero-extended to XLEN. Enables drop and the FSM goes to RESP next cycle. Minimum load/store latency is accept to resp_valid = 2 cycles.
- ACCESS with dhit=0: the counter increments. When MAX_WAIT≠0 and the counter reaches MAX_WAIT, enables drop and the FSM goes to RESP with err 10.
- RESP: resp_valid=1 for exactly one cycle, carrying resp_data, resp_rd and resp_err. Next state is IDLE. The counter is cleared.
- req_valid during ACCESS or RESP is not accepted and must be held by the requester.
- dhit while in IDLE or RESP is ignored.
- Unsigned W on XLEN=32 equals signed W.
- resp_data, resp_rd and resp_err hold their last values outside RESP. Only resp_valid qualifies them.

Test Plan:
- XLEN=32, load B signed at addr 0x1003, dmem_load=0x80_00_00_00, dhit on the 1st ACCESS cycle → dmem_addr 0x1000; resp_data 0xFFFFFF80; resp_valid at accept+2; stall drops the same cycle.
- XLEN=32, store H at addr 0x2002, wdata 0x0000BEEF → dmem_store 0xBEEF0000, dmem_strobe 0b1100, dmem_wen held through 3 dhit=0 cycles, resp_err 00.
- XLEN=64, load W unsigned at addr 0x10, dmem_load 0xFFFFFFFF_80000000 → strobe-free read, resp_data 0x00000000_80000000; the same load signed → 0xFFFFFFFF_80000000.
- Misaligned: load W at addr 0x3001 → dmem_ren never asserted, resp_err 01 at accept+1; width 11 with XLEN=32 → resp_err 11.
- MAX_WAIT=4, dhit held 0 → dmem_ren high for exactly 4 cycles, resp_err 10, back to IDLE; a late dhit is ignored.
- rst pulsed mid-ACCESS → dmem_ren/dmem_wen/stall drop immediately (asynchronous). After release, req_ready=1 and a new load completes normally.

Source files
------------

// File: rtl/lsu_ctrl.sv
//----------------------------------------------------------------------------
// lsu_ctrl : load/store unit, core request handshake to data-memory port
//            with lane alignment, strobes, misalign/timeout detection.
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module lsu_ctrl #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [1:0]          req_width,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  input  logic [4:0]          req_rd,
  output logic                resp_valid,
  output logic [XLEN-1:0]     resp_data,
  output logic [4:0]          resp_rd,
  output logic [1:0]          resp_err,
  output logic                stall,
  output logic                dmem_ren,
  output logic                dmem_wen,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [XLEN-1:0]     dmem_store,
  output logic [XLEN/8-1:0]   dmem_strobe,
  input  logic [XLEN-1:0]     dmem_load,
  input  logic                dhit
);

  localparam int c_strb_w = XLEN / 8;
  localparam int c_lane_w = $clog2(c_strb_w);
  localparam int c_cnt_w  = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_max = c_cnt_w'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic                  r_st;
  logic [1:0]            r_width;
  logic                  r_uns;
  logic [ADDR_W-1:0]     r_addr;
  logic [XLEN-1:0]       r_wdata;
  logic [4:0]            r_rd;
  logic                  r_dmem_ren;
  logic                  r_dmem_wen;
  logic [c_cnt_w-1:0]    r_cnt;
  logic [XLEN-1:0]       r_resp_data;
  logic [4:0]            r_resp_rd;
  logic [1:0]            r_resp_err;

  logic [1:0]            w_chk_err;
  logic [c_lane_w-1:0]   w_lane;
  logic [c_lane_w+2:0]   w_shamt;
  logic [XLEN-1:0]       w_shift;
  logic [XLEN-1:0]       w_mask;
  logic                  w_sign;
  logic [XLEN-1:0]       w_load;
  logic [c_strb_w-1:0]   w_size_strb;
  logic [c_cnt_w-1:0]    w_cnt_inc;
  logic                  w_timeout;
  logic                  w_in_access;

  // Illegal width takes priority over misalignment.
  always_comb begin
    w_chk_err = 2'b00;
    if (req_width == 2'b11 && XLEN == 32) begin
      w_chk_err = 2'b11;
    end else begin
      case (req_width)
        2'b01:   if (req_addr[0])      w_chk_err = 2'b01;
        2'b10:   if (|req_addr[1:0])   w_chk_err = 2'b01;
        2'b11:   if (|req_addr[2:0])   w_chk_err = 2'b01;
        default: w_chk_err = 2'b00;
      endcase
    end
  end

  assign w_lane  = r_addr[c_lane_w-1:0];
  assign w_shamt = {w_lane, 3'b000};
  assign w_shift = dmem_load >> w_shamt;

  always_comb begin
    w_mask      = '1;
    w_sign      = 1'b0;
    w_size_strb = '1;
    case (r_width)
      2'b00: begin
        w_mask      = XLEN'(8'hFF);
        w_sign      = w_shift[7];
        w_size_strb = c_strb_w'(4'h1);
      end
      2'b01: begin
        w_mask      = XLEN'(16'hFFFF);
        w_sign      = w_shift[15];
        w_size_strb = c_strb_w'(4'h3);
      end
      2'b10: begin
        w_mask      = XLEN'(32'hFFFF_FFFF);
        w_sign      = w_shift[31];
        w_size_strb = c_strb_w'(4'hF);
      end
      default: begin
        w_mask      = '1;
        w_sign      = 1'b0;
        w_size_strb = '1;
      end
    endcase
  end

  assign w_load = (w_shift & w_mask) | ((!r_uns && w_sign) ? ~w_mask : '0);

  assign w_cnt_inc = r_cnt + c_cnt_w'(1);
  assign w_timeout = (MAX_WAIT != 0) && !dhit && (w_cnt_inc == c_max);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_state_nxt = (w_chk_err != 2'b00) ? RESP : ACCESS;
      ACCESS:  if (dhit || w_timeout) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st        <= 1'b0;
      r_width     <= 2'b00;
      r_uns       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rd        <= '0;
      r_dmem_ren  <= 1'b0;
      r_dmem_wen  <= 1'b0;
      r_cnt       <= '0;
      r_resp_data <= '0;
      r_resp_rd   <= '0;
      r_resp_err  <= 2'b00;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_st    <= req_wen;
            r_width <= req_width;
            r_uns   <= req_unsigned;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_rd    <= req_rd;
            r_cnt   <= '0;
            if (w_chk_err != 2'b00) begin
              r_resp_data <= '0;
              r_resp_rd   <= req_rd;
              r_resp_err  <= w_chk_err;
            end else begin
              r_dmem_ren <= !req_wen;
              r_dmem_wen <= req_wen;
            end
          end
        end
        ACCESS: begin
          if (dhit) begin
            r_dmem_ren  <= 1'b0;
            r_dmem_wen  <= 1'b0;
            r_resp_data <= r_st ? '0 : w_load;
            r_resp_rd   <= r_rd;
            r_resp_err  <= 2'b00;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_timeout) begin
              r_dmem_ren  <= 1'b0;
              r_dmem_wen  <= 1'b0;
              r_resp_data <= '0;
              r_resp_rd   <= r_rd;
              r_resp_err  <= 2'b10;
            end
          end
        end
        RESP: begin
          r_cnt <= '0;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign w_in_access = (r_state == ACCESS);

  assign req_ready   = !rst && (r_state == IDLE);
  assign stall       = !rst && (((r_state == IDLE) && req_valid) || w_in_access);
  assign resp_valid  = (r_state == RESP);
  assign resp_data   = r_resp_data;
  assign resp_rd     = r_resp_rd;
  assign resp_err    = r_resp_err;
  assign dmem_ren    = r_dmem_ren;
  assign dmem_wen    = r_dmem_wen;
  assign dmem_addr   = {r_addr[ADDR_W-1:c_lane_w], {c_lane_w{1'b0}}};
  assign dmem_store  = (w_in_access && r_st) ? (r_wdata << w_shamt) : '0;
  assign dmem_strobe = (w_in_access && r_st) ? (w_size_strb << w_lane) : '0;

endmodule

`default_nettype wire
